prog_sequencer: RTL and testbench

Hardware sequencer that runs the three processor programs (P1, P2, P3) back-to-back on TopLevel without bench intervention. On one Go pulse it drives TopLevel's Start/start-address inputs for each program in turn, waits for the core's Ack, records per-program cycle counts and flags completion or timeout. It sits between the bench/host and TopLevel and is the only driver of the core's Start line.

---
 rtl/prog_sequencer_if.sv | 34 +++
 rtl/prog_sequencer.sv | 164 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer_if
// Description : Host/core-facing signal bundle of the program sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Go;
    logic             Ack;
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic [1:0]       ProgIdx;
    logic             Busy;
    logic             AllDone;
    logic             TimedOut;
    logic [CNT_W-1:0] CycleCount;
    logic             CountValid;

    modport slave (
        input  Go, Ack,
        output Start, StartAddr, ProgIdx, Busy, AllDone, TimedOut,
               CycleCount, CountValid
    );

    modport master (
        output Go, Ack,
        input  Start, StartAddr, ProgIdx, Busy, AllDone, TimedOut,
               CycleCount, CountValid
    );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : Launches programs P1..P3 back-to-back on the core, times
//               each run and reports completion or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter int PC_W      = 10,
    parameter int CNT_W     = 16,
    parameter int BASE0     = 0,
    parameter int BASE1     = 128,
    parameter int BASE2     = 256,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic             Clk,
    input  logic             Reset,
    prog_sequencer_if.slave  bus
);
    localparam int LC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [LC_W-1:0]  c_LAUNCH_LAST = LC_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] c_RUN_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic [LC_W-1:0]  r_launch_cnt, w_launch_nxt;
    logic [CNT_W-1:0] r_run_cnt,    w_run_nxt;
    logic [1:0]       r_prog_idx,   w_idx_nxt;
    logic             r_start,      w_start_nxt;
    logic [PC_W-1:0]  r_start_addr, w_addr_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_all_done,   w_done_nxt;
    logic             r_timed_out,  w_to_nxt;
    logic [CNT_W-1:0] r_cycle_cnt,  w_cc_nxt;
    logic             r_count_vld,  w_cv_nxt;
    logic             w_launch_req;
    logic [1:0]       w_launch_idx;

    function automatic logic [PC_W-1:0] f_base(input logic [1:0] idx);
        case (idx)
            2'd0:    f_base = PC_W'(BASE0);
            2'd1:    f_base = PC_W'(BASE1);
            default: f_base = PC_W'(BASE2);
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_launch_cnt <= '0;
            r_run_cnt    <= '0;
            r_prog_idx   <= 2'd0;
            r_start      <= 1'b0;
            r_start_addr <= PC_W'(BASE0);
            r_busy       <= 1'b0;
            r_all_done   <= 1'b0;
            r_timed_out  <= 1'b0;
            r_cycle_cnt  <= '0;
            r_count_vld  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_launch_cnt <= w_launch_nxt;
            r_run_cnt    <= w_run_nxt;
            r_prog_idx   <= w_idx_nxt;
            r_start      <= w_start_nxt;
            r_start_addr <= w_addr_nxt;
            r_busy       <= w_busy_nxt;
            r_all_done   <= w_done_nxt;
            r_timed_out  <= w_to_nxt;
            r_cycle_cnt  <= w_cc_nxt;
            r_count_vld  <= w_cv_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_launch_nxt = r_launch_cnt;
        w_run_nxt    = r_run_cnt;
        w_idx_nxt    = r_prog_idx;
        w_start_nxt  = r_start;
        w_addr_nxt   = r_start_addr;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_all_done;
        w_to_nxt     = r_timed_out;
        w_cc_nxt     = r_cycle_cnt;
        w_cv_nxt     = 1'b0;
        w_launch_req = 1'b0;
        w_launch_idx = 2'd0;

        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (bus.Go) begin
                    w_launch_req = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (r_launch_cnt == c_LAUNCH_LAST) begin
                    w_state_nxt = S_RUN;
                    w_start_nxt = 1'b0;
                    w_run_nxt   = '0;
                end else begin
                    w_launch_nxt = r_launch_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // The count excludes the sample that sees Ack high.
                if (bus.Ack) begin
                    w_state_nxt = S_NEXT;
                    w_cc_nxt    = r_run_cnt;
                    w_cv_nxt    = 1'b1;
                end else if (r_run_cnt == c_RUN_LAST) begin
                    w_state_nxt = S_FAULT;
                    w_busy_nxt  = 1'b0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_run_nxt = r_run_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (r_prog_idx == 2'd2) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_launch_req = 1'b1;
                    w_launch_idx = r_prog_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_launch_req) begin
            w_state_nxt  = S_LAUNCH;
            w_idx_nxt    = w_launch_idx;
            w_start_nxt  = 1'b1;
            w_addr_nxt   = f_base(w_launch_idx);
            w_busy_nxt   = 1'b1;
            w_done_nxt   = 1'b0;
            w_to_nxt     = 1'b0;
            w_launch_nxt = '0;
        end
    end

    assign bus.Start      = r_start;
    assign bus.StartAddr  = r_start_addr;
    assign bus.ProgIdx    = r_prog_idx;
    assign bus.Busy       = r_busy;
    assign bus.AllDone    = r_all_done;
    assign bus.TimedOut   = r_timed_out;
    assign bus.CycleCount = r_cycle_cnt;
    assign bus.CountValid = r_count_vld;
endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Directed/random bench for prog_sequencer (START_CYC=2 and =1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;
    localparam int TIMEOUT = 4096;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic go    = 1'b0;
    logic ack   = 1'b0;
    int   sel   = 0;
    int   total = 0;
    int   bad   = 0;

    prog_sequencer_if #(.PC_W(10), .CNT_W(16)) u_if0 ();
    prog_sequencer_if #(.PC_W(10), .CNT_W(16)) u_if1 ();

    prog_sequencer #(
        .PC_W(10), .CNT_W(16), .BASE0(0), .BASE1(128), .BASE2(256),
        .START_CYC(2), .TIMEOUT(TIMEOUT)
    ) u_dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (u_if0.slave)
    );

    prog_sequencer #(
        .PC_W(10), .CNT_W(16), .BASE0(0), .BASE1(128), .BASE2(256),
        .START_CYC(1), .TIMEOUT(TIMEOUT)
    ) u_dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (u_if1.slave)
    );

    assign u_if0.Go  = go  && (sel == 0);
    assign u_if0.Ack = ack && (sel == 0);
    assign u_if1.Go  = go  && (sel == 1);
    assign u_if1.Ack = ack && (sel == 1);

    logic        obs_start, obs_busy, obs_done, obs_to, obs_cv;
    logic [9:0]  obs_addr;
    logic [1:0]  obs_idx;
    logic [15:0] obs_cc;

    always_comb begin
        if (sel == 1) begin
            obs_start = u_if1.Start;     obs_addr = u_if1.StartAddr;
            obs_idx   = u_if1.ProgIdx;   obs_busy = u_if1.Busy;
            obs_done  = u_if1.AllDone;   obs_to   = u_if1.TimedOut;
            obs_cc    = u_if1.CycleCount; obs_cv  = u_if1.CountValid;
        end else begin
            obs_start = u_if0.Start;     obs_addr = u_if0.StartAddr;
            obs_idx   = u_if0.ProgIdx;   obs_busy = u_if0.Busy;
            obs_done  = u_if0.AllDone;   obs_to   = u_if0.TimedOut;
            obs_cc    = u_if0.CycleCount; obs_cv  = u_if0.CountValid;
        end
    end

    always #5 Clk = ~Clk;

    // Reference rules: program i starts at i*128, Start lasts START_CYC cycles,
    // and Ack raised d cycles after Start falls yields a count of d.
    function automatic int exp_base(input int i);
        return i * 128;
    endfunction

    function automatic int exp_start_len();
        return (sel == 1) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_start", obs_start, 0);
        chk("rst_addr",  obs_addr,  0);
        chk("rst_idx",   obs_idx,   0);
        chk("rst_busy",  obs_busy,  0);
        chk("rst_done",  obs_done,  0);
        chk("rst_to",    obs_to,    0);
        chk("rst_cc",    obs_cc,    0);
        chk("rst_cv",    obs_cv,    0);
    endtask

    task automatic launch_check(input int idx, input bit drop, input int exp_gap);
        int n = 0;
        while (!obs_start && n < 50) begin
            step();
            n++;
        end
        chk("launch_gap", n, exp_gap);
        if (drop) ack = 1'b0;
        chk("start_addr", obs_addr, exp_base(idx));
        chk("launch_idx", obs_idx, idx);
        chk("launch_busy", obs_busy, 1);
        n = 0;
        while (obs_start && n < 10) begin
            n++;
            step();
        end
        chk("start_len", n, exp_start_len());
    endtask

    task automatic run_ack(input int d, input bit jiggle, input int idx);
        for (int j = 0; j < d; j++) begin
            if (jiggle) go = (j % 2 == 0);
            step();
        end
        go = 1'b0;
        chk("run_cv_low", obs_cv, 0);
        chk("run_start_low", obs_start, 0);
        chk("run_idx", obs_idx, idx);
        ack = 1'b1;
        step();
        chk("cv_pulse", obs_cv, 1);
        chk("cycle_count", obs_cc, d);
    endtask

    task automatic do_programs(input int d[3], input bit jiggle, input bit nodrop0);
        for (int i = 0; i < 3; i++) begin
            launch_check(i, !(nodrop0 && i == 0), (i == 0) ? 0 : 1);
            run_ack(d[i], jiggle && i == 0, i);
        end
        step();
        chk("done_flag", obs_done, 1);
        chk("done_busy", obs_busy, 0);
        chk("done_idx",  obs_idx,  2);
        chk("done_cc",   obs_cc,   d[2]);
        chk("done_cv",   obs_cv,   0);
    endtask

    task automatic full_pass(input int d[3], input bit jiggle, input bit nodrop0);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("go_done_clr", obs_done, 0);
        chk("go_to_clr", obs_to, 0);
        do_programs(d, jiggle, nodrop0);
    endtask

    initial begin
        int d[3];
        int p1;
        repeat (3) step();
        chk_reset_vals();
        Reset = 1'b0;

        d = '{10, 20, 30};
        full_pass(d, 1'b0, 1'b0);

        d[0] = int'($urandom_range(1, 60));
        d[1] = int'($urandom_range(1, 60));
        d[2] = int'($urandom_range(1, 60));
        full_pass(d, 1'b1, 1'b0);
        full_pass(d, 1'b0, 1'b0);

        ack  = 1'b1;
        d[0] = 0;
        d[1] = int'($urandom_range(0, 40));
        d[2] = int'($urandom_range(0, 40));
        full_pass(d, 1'b0, 1'b1);

        // P2 never acknowledges.
        p1 = int'($urandom_range(1, 50));
        go = 1'b1;
        step();
        go = 1'b0;
        launch_check(0, 1'b1, 0);
        run_ack(p1, 1'b0, 0);
        launch_check(1, 1'b1, 1);
        repeat (TIMEOUT - 1) step();
        chk("to_early", obs_to, 0);
        chk("to_early_busy", obs_busy, 1);
        step();
        chk("to_flag", obs_to, 1);
        chk("to_idx", obs_idx, 1);
        chk("to_busy", obs_busy, 0);
        chk("to_cc", obs_cc, p1);
        chk("to_done", obs_done, 0);
        d[0] = int'($urandom_range(1, 30));
        d[1] = int'($urandom_range(1, 30));
        d[2] = int'($urandom_range(1, 30));
        go = 1'b1;
        step();
        go = 1'b0;
        chk("restart_to", obs_to, 0);
        chk("restart_start", obs_start, 1);
        do_programs(d, 1'b0, 1'b0);

        // Reset together with Go in the middle of P2's run.
        go = 1'b1;
        step();
        go = 1'b0;
        launch_check(0, 1'b1, 0);
        run_ack(5, 1'b0, 0);
        launch_check(1, 1'b1, 1);
        repeat (3) step();
        Reset = 1'b1;
        go    = 1'b1;
        step();
        Reset = 1'b0;
        go    = 1'b0;
        chk_reset_vals();
        repeat (5) step();
        chk("idle_start", obs_start, 0);
        chk("idle_busy", obs_busy, 0);
        full_pass(d, 1'b0, 1'b0);

        sel = 1;
        ack = 1'b0;
        d   = '{10, 20, 30};
        full_pass(d, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
